// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: bit-serial RV32M unsigned MUL/MULHU/DIVU/REMU sequencer that stalls EX until done
module muldiv_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [9:0]       funct_i,
  input  logic [1:0]       ALUOp_i,
  input  logic [WIDTH-1:0] rs1_data_i,
  input  logic [WIDTH-1:0] rs2_data_i,
  input  logic             flush_i,
  output logic             stall_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] result_o
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [WIDTH:0] acc, acc_nx, sum, shl;
  logic [WIDTH-1:0] low, low_nx, dvs, quick;
  logic hi, accept, go, last, fits, is_mul, is_div;
  always_comb begin
    accept = start_i && ALUOp_i == 2'b10 && funct_i[9:3] == 7'b0000001 && state == IDLE;
    go = accept && !flush_i;
    last = cnt == CW'(WIDTH - 1);
    stall_o = accept || state == MUL || state == DIV;
    valid_o = state == DONE;
    is_mul = !funct_i[2] && funct_i[1] == funct_i[0];
    is_div = funct_i[2] && funct_i[0] && |rs2_data_i;
    sum = acc + (low[0] ? {1'b0, dvs} : '0);
    shl = {acc[WIDTH-1:0], low[WIDTH-1]};
    fits = shl >= {1'b0, dvs};
    acc_nx = state == MUL ? sum >> 1 : (fits ? shl - {1'b0, dvs} : shl);
    low_nx = state == MUL ? {sum[0], low[WIDTH-1:1]} : {low[WIDTH-2:0], fits};
    // Ops that finish without iterating: divide by zero and the signed variants we do not support
    quick = funct_i[2:0] == 3'b101 ? '1 : funct_i[2:0] == 3'b111 ? rs1_data_i : '0;
    state_nx = flush_i ? IDLE :
               state == IDLE ? (go ? (is_mul ? MUL : is_div ? DIV : DONE) : IDLE) :
               state == DONE ? IDLE :
               last ? DONE : state;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      cnt <= '0;
      acc <= '0;
      low <= '0;
      dvs <= '0;
      hi <= 1'b0;
      result_o <= '0;
    end else begin
      state <= state_nx;
      if (go) begin
        cnt <= '0;
        acc <= '0;
        low <= rs1_data_i;
        dvs <= rs2_data_i;
        hi <= funct_i[1];
        if (state_nx == DONE) result_o <= quick;
      end else if (!flush_i && (state == MUL || state == DIV)) begin
        cnt <= cnt + 1'b1;
        acc <= acc_nx;
        low <= low_nx;
        // funct3[1] selects the upper half (MULHU) or remainder (REMU)
        if (last) result_o <= hi ? acc_nx[WIDTH-1:0] : low_nx;
      end
    end
  end
endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: directed scoreboard bench for the multiply/divide sequencer
module tb_muldiv_ctrl;
  localparam int W = 32;
  logic clk = 0, rst, start, flush, stall, valid;
  logic [9:0] funct;
  logic [1:0] aluop;
  logic [W-1:0] a, b, res;
  logic [W-1:0] q[$];
  int total = 0, passed = 0;
  muldiv_ctrl #(.WIDTH(W)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .funct_i(funct), .ALUOp_i(aluop),
    .rs1_data_i(a), .rs2_data_i(b), .flush_i(flush),
    .stall_o(stall), .valid_o(valid), .result_o(res)
  );
  always #5 clk = ~clk;
  task automatic chk(string tag, logic [W-1:0] obs, logic [W-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask
  function automatic logic [W-1:0] model(logic [2:0] f, logic [W-1:0] x, logic [W-1:0] y);
    logic [2*W-1:0] p;
    p = 64'(x) * 64'(y);
    case (f)
      3'b000: return p[W-1:0];
      3'b011: return p[2*W-1:W];
      3'b101: return y == 0 ? '1 : x / y;
      3'b111: return y == 0 ? x : x % y;
      default: return '0;
    endcase
  endfunction
  task automatic op(string tag, logic [2:0] f, logic [W-1:0] x, logic [W-1:0] y, bit noise);
    int lat;
    lat = (f == 3'b000 || f == 3'b011 || ((f == 3'b101 || f == 3'b111) && y != 0)) ? W + 1 : 1;
    q.push_back(model(f, x, y));
    @(negedge clk);
    start = 1; aluop = 2'b10; funct = {7'b0000001, f}; a = x; b = y;
    #1 chk({tag, " stall c0"}, W'(stall), 1);
    for (int c = 1; c <= lat + 1; c++) begin
      @(negedge clk);
      start = noise && c < lat; funct = {7'b0000001, 3'b111}; a = $urandom; b = $urandom | 1;
      #1;
      if (c < lat) chk($sformatf("%s busy c%0d", tag, c), W'({stall, valid}), 2);
      else if (c == lat) begin
        chk($sformatf("%s done c%0d", tag, c), W'({stall, valid}), 1);
        chk({tag, " result"}, res, q.pop_front());
      end else chk({tag, " idle"}, W'({stall, valid}), 0);
    end
    start = 0;
  endtask
  task automatic abort(string tag, bit use_rst, logic [W-1:0] exp_res);
    int seen;
    @(negedge clk);
    start = 1; aluop = 2'b10; funct = 10'b0000001_000; a = 3; b = 5;
    #1 chk({tag, " stall c0"}, W'(stall), 1);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      start = 0; flush = !use_rst && c == 10; rst = use_rst && c == 10;
      #1 chk($sformatf("%s busy c%0d", tag, c), W'({stall, valid}), 2);
    end
    @(negedge clk);
    flush = 0; rst = 0;
    #1 chk({tag, " c11 outputs"}, W'({stall, valid}), 0);
    chk({tag, " c11 result"}, res, exp_res);
    seen = 0;
    repeat (36) begin
      @(negedge clk);
      #1 seen += int'(valid) + int'(stall);
    end
    chk({tag, " quiet"}, W'(seen), 0);
  endtask
  initial begin
    rst = 1; start = 0; flush = 0; funct = 0; aluop = 0; a = 0; b = 0;
    repeat (2) @(negedge clk);
    #1 chk("reset outputs", W'({stall, valid}), 0);
    chk("reset result", res, 0);
    rst = 0;
    op("mul", 3'b000, 7, 6, 0);
    op("mulhu_max", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    op("mul_max", 3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    op("divu", 3'b101, 100, 7, 1);
    op("remu", 3'b111, 100, 7, 1);
    op("divu_big", 3'b101, 32'h8000_0000, 1, 0);
    op("mulhu_rand", 3'b011, 32'h1234_5678, 32'h9ABC_DEF1, 0);
    op("remu_rand", 3'b111, 32'hDEAD_BEEF, 32'h0001_2345, 0);
    op("unsup", 3'b001, 9, 3, 0);
    op("divu0", 3'b101, 5, 0, 0);
    op("remu0", 3'b111, 5, 0, 0);
    abort("flush", 0, 5);
    op("mul_after_flush", 3'b000, 1234, 5678, 0);
    abort("reset", 1, 0);
    @(negedge clk);
    start = 1; aluop = 2'b10; funct = 10'b0000000_000; a = 1; b = 2;
    #1 chk("add stall", W'(stall), 0);
    @(negedge clk);
    aluop = 2'b00; funct = 10'b0000001_000;
    #1 chk("add no state", W'({stall, valid}), 0);
    chk("non-rtype stall", W'(stall), 0);
    @(negedge clk);
    start = 0;
    #1 chk("non-rtype no state", W'({stall, valid}), 0);
    op("mul_after_add", 3'b000, 32'hFFFF, 32'h10001, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
